// File: rtl/sprite_ram_clr.sv
// Sprite attribute RAM: byte-enabled write port, registered read port, hardware clear engine.
// Define SPRITE_RAM_BYPASS_EN to forward same-cycle same-address writes into the read data.
module sprite_ram_clr #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W/8-1:0]   ben_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  clr_req_i,
    output logic                  busy_o
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                busy_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   rd_word_d;
    logic [DATA_W-1:0]   s1_data_q;
    logic                s1_valid_q;

    assign cnt_d = cnt_q + ADDR_W'(1);

    // Control FSM: clear sweep after reset or on request, then idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array write: clear engine owns the port while clearing; contents untouched in reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (wr_en_i) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (ben_i[b]) begin
                        mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read word selection; array reads return pre-write contents unless forwarding is built.
    always_comb begin
        rd_word_d = mem[rd_addr_i];
`ifdef SPRITE_RAM_BYPASS_EN
        if ((state_q == ST_IDLE) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (ben_i[b]) begin
                    rd_word_d[8*b +: 8] = wr_data_i[8*b +: 8];
                end
            end
        end
`else
`endif
        if (state_q == ST_CLEAR) begin
            rd_word_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_en_i;
            if (rd_en_i) begin
                s1_data_q <= rd_word_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_valid_q;

            // Optional retiming stage; holds data between valid reads.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_data_o  = s2_data_q;
            assign rd_valid_o = s2_valid_q;
        end else begin : g_no_out_reg
            assign rd_data_o  = s1_data_q;
            assign rd_valid_o = s1_valid_q;
        end
    endgenerate

    assign busy_o = busy_q;

endmodule

// File: tb/tb_sprite_ram_clr.sv
// Directed bench for sprite_ram_clr: one OUT_REG=0 and one OUT_REG=1 instance on shared stimulus.
module tb_sprite_ram_clr;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [3:0]  ben_i;
    logic [7:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        rd_en_i;
    logic [7:0]  rd_addr_i;
    logic        clr_req_i;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    sprite_ram_clr #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .ben_i(ben_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0),
        .clr_req_i(clr_req_i), .busy_o(busy0)
    );

    sprite_ram_clr #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .ben_i(ben_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data1), .rd_valid_o(rd_valid1),
        .clr_req_i(clr_req_i), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        wr_en_i   = 1'b0;
        ben_i     = 4'h0;
        wr_addr_i = 8'h00;
        wr_data_i = 32'h0;
        rd_en_i   = 1'b0;
        rd_addr_i = 8'h00;
        clr_req_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; ben_i = be;
        tick();
        wr_en_i = 1'b0; ben_i = 4'h0;
    endtask

    // Single read checked on both instances (latency 1 and 2).
    task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        rd_en_i = 1'b1; rd_addr_i = a;
        tick();
        rd_en_i = 1'b0;
        chk({tag, "_v0"}, 32'(rd_valid0), 32'd1);
        chk({tag, "_d0"}, rd_data0, exp);
        tick();
        chk({tag, "_v1"}, 32'(rd_valid1), 32'd1);
        chk({tag, "_d1"}, rd_data1, exp);
    endtask

    // Counts cycles busy_o stays high, starting at the current sample point.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 600) begin
            n++;
            tick();
        end
    endtask

    logic [31:0] exp_merge;
    int          nb;

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_busy0",  32'(busy0), 32'd1);
        chk("rst_busy1",  32'(busy1), 32'd1);
        chk("rst_valid0", 32'(rd_valid0), 32'd0);
        chk("rst_valid1", 32'(rd_valid1), 32'd0);
        chk("rst_data0",  rd_data0, 32'h0);
        chk("rst_data1",  rd_data1, 32'h0);

        rst_i = 1'b0;
        count_busy(nb);
        chk("init_clear_len", 32'(nb), 32'd256);
        chk("init_busy1", 32'(busy1), 32'd0);
        do_read("rd_ff_after_init", 8'hFF, 32'h0);

        // rd_en low: no valid pulse, data held
        tick();
        chk("noread_valid0", 32'(rd_valid0), 32'd0);
        chk("noread_hold0",  rd_data0, 32'h0);

        // Byte-enable merge
        do_write(8'h10, 32'hDEADBEEF, 4'hF);
        do_write(8'h10, 32'h11223344, 4'h5);
        do_read("ben_merge", 8'h10, 32'hDE22BE44);

        // ben = 0 is a no-op
        do_write(8'h30, 32'h12345678, 4'hF);
        do_write(8'h30, 32'hFFFFFFFF, 4'h0);
        do_read("ben_zero", 8'h30, 32'h12345678);

        // Same-cycle same-address read/write
        do_write(8'h20, 32'h01020304, 4'hF);
`ifdef SPRITE_RAM_BYPASS_EN
        exp_merge = 32'h0102CCDD;
`else
        exp_merge = 32'h01020304;
`endif
        wr_en_i = 1'b1; wr_addr_i = 8'h20; wr_data_i = 32'hAABBCCDD; ben_i = 4'h3;
        rd_en_i = 1'b1; rd_addr_i = 8'h20;
        tick();
        wr_en_i = 1'b0; rd_en_i = 1'b0; ben_i = 4'h0;
        chk("rw_same_d0", rd_data0, exp_merge);
        tick();
        chk("rw_same_d1", rd_data1, exp_merge);
        do_read("rw_after", 8'h20, 32'h0102CCDD);

        // Fill whole array
        for (int a = 0; a < 256; a++) begin
            do_write(8'(a), 32'h5A000000 | 32'(a), 4'hF);
        end
        do_read("fill_00", 8'h00, 32'h5A000000);
        do_read("fill_ff", 8'hFF, 32'h5A0000FF);

        // Clear request with a concurrent write, mid-clear write/read/second request
        clr_req_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = 8'h40; wr_data_i = 32'hCAFEF00D; ben_i = 4'hF;
        tick();
        idle_inputs();
        nb = 0;
        while (busy0 && nb < 600) begin
            nb++;
            idle_inputs();
            if (nb == 50) begin
                wr_en_i = 1'b1; wr_addr_i = 8'h05; wr_data_i = 32'h77777777; ben_i = 4'hF;
            end
            if (nb == 100) clr_req_i = 1'b1;
            if (nb == 120) begin
                rd_en_i = 1'b1; rd_addr_i = 8'hFF;
            end
            if (nb == 121) begin
                chk("clr_rd_valid0", 32'(rd_valid0), 32'd1);
                chk("clr_rd_data0",  rd_data0, 32'h0);
            end
            tick();
        end
        idle_inputs();
        chk("req_clear_len", 32'(nb), 32'd256);
        for (int a = 0; a < 256; a++) begin
            do_read("post_clr", 8'(a), 32'h0);
        end

        // Back-to-back reads through both pipelines
        for (int a = 0; a < 8; a++) begin
            do_write(8'(a), 32'hC0DE0000 + 32'(a), 4'hF);
        end
        for (int k = 0; k < 11; k++) begin
            if (k >= 1) begin
                chk("b2b_v0", 32'(rd_valid0), 32'(k <= 8));
                if (k <= 8) chk("b2b_d0", rd_data0, 32'hC0DE0000 + 32'(k - 1));
            end
            if (k >= 2) begin
                chk("b2b_v1", 32'(rd_valid1), 32'(k <= 9));
                if (k <= 9) chk("b2b_d1", rd_data1, 32'hC0DE0000 + 32'(k - 2));
            end
            rd_en_i   = (k < 8);
            rd_addr_i = 8'(k);
            tick();
        end
        idle_inputs();

        // Reset at clear count 100 with a read in flight
        clr_req_i = 1'b1;
        tick();
        clr_req_i = 1'b0;
        repeat (99) tick();
        rd_en_i = 1'b1; rd_addr_i = 8'h03;
        tick();
        rd_en_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("midrst_valid0", 32'(rd_valid0), 32'd0);
        chk("midrst_valid1", 32'(rd_valid1), 32'd0);
        chk("midrst_busy0",  32'(busy0), 32'd1);
        repeat (2) tick();
        chk("midrst_valid1b", 32'(rd_valid1), 32'd0);
        chk("midrst_data1",   rd_data1, 32'h0);
        rst_i = 1'b0;
        count_busy(nb);
        chk("midrst_clear_len", 32'(nb), 32'd256);
        do_read("midrst_rd", 8'h07, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
